data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory responder on the far side of the per-lane LSU request interface driven by each SIMD unit. It accepts up to LANE_WIDTH concurrent read/write requests, grants up to NUM_CHANNELS of them per cycle in round-robin order, and services them against an internal word-addressed data memory. Each request is returned as a one-cycle ack after a fixed latency, with read data on the same cycle. It sits between the SIMD unit's LSU outputs and the compute unit's data memory.

## Interface
- DATA_WIDTH, 64, data word width
- ADDR_WIDTH, 7, word address width; memory depth is 2^ADDR_WIDTH words
- LANE_WIDTH, 16, number of requesting lanes
- NUM_CHANNELS, 4, maximum grants per cycle (1..LANE_WIDTH)
- MEM_LATENCY, 2, cycles from grant edge to ack (>=1)

Ports:
- clk  in  1  clock; one clock domain, all state on rising edge
- rst  in  1  synchronous reset, active-high
- mem_read_valid  in  LANE_WIDTH  per-lane read request; held until acked
- mem_write_valid  in  LANE_WIDTH  per-lane write request; held until acked
- mem_addr  in  ADDR_WIDTH x LANE_WIDTH  per-lane word address
- mem_write_data  in  DATA_WIDTH x LANE_WIDTH  per-lane write data
- data_mem_ready_ack  out  LANE_WIDTH  one-cycle read-complete pulse per lane
- data_mem_write_ack  out  LANE_WIDTH  one-cycle write-complete pulse per lane
- mem_read_data  out  DATA_WIDTH x LANE_WIDTH  read data, valid while that lane's ready_ack is high
- mem_busy  out  1  high while any lane is in WAIT

## Operation
- Per-lane state, 2 bits: IDLE, WAIT (granted, in flight), DONE (acked, waiting for requester to drop valid).
- Eligible lane: state IDLE and (read_valid or write_valid).
- Round-robin pointer rr, width clog2(LANE_WIDTH), reset 0. Each cycle, scan lanes rr, rr+1, ... modulo LANE_WIDTH and grant the first min(NUM_CHANNELS, eligible count) eligible lanes.
- rr moves to (last granted lane + 1) mod LANE_WIDTH. It is unchanged if nothing is granted.
- At the grant edge:
  - A granted write stores mem_write_data into mem[mem_addr].
  - A granted read captures mem[mem_addr].
  - The lane moves to WAIT, and a MEM_LATENCY-deep delay line records {lane, is_write, data}.
- Read and write both asserted on one lane: the write is granted. The read remains pending and is served after the lane returns to IDLE.
- Same-cycle ordering:
  - Reads observe memory before that edge's writes.
  - Multiple writes to one address on one edge: the last lane in scan order wins.
- When an entry exits the delay line:
  - Pulse the matching ack for exactly one cycle.
  - For reads, drive mem_read_data[lane] with the captured data.
  - Move the lane WAIT -> DONE.
- DONE -> IDLE when both of that lane's valids are low. A lane whose valid stays high after its ack is never re-served until valid drops for at least one cycle.
- Outside its ack cycle, mem_read_data[lane] holds its last value.
- mem_busy = OR over lanes of (state == WAIT).
- Address arithmetic is unsigned and has no wrap logic; the full address range is legal.

## Timing
- Reset values:
  - All acks 0, mem_read_data all 0, mem_busy 0.
  - All lane states IDLE, rr 0, delay line empty.
  - All memory words 0.
- Latency:
  - A request first visible in cycle T with its lane eligible is granted at the end of T.
  - Its ack is high in cycle T+MEM_LATENCY.
  - With MEM_LATENCY=1, the ack is high in the cycle after the request.
- Throughput: NUM_CHANNELS grants per cycle, sustained. The minimum per-lane repeat interval is MEM_LATENCY+2 cycles: ack, then valid low for one cycle, then the new request.
- rst asserted mid-operation:
  - In-flight entries are discarded and no ack is issued for them.
  - Memory is zeroed.
  - On the first cycle after rst deasserts, every lane is IDLE, and requests still held are re-arbitrated from rr=0.
- Valid deasserted while a lane is in WAIT is a protocol violation. The ack still fires, and the lane goes DONE and then IDLE.

## Test plan
- Lane 3 writes 64'hDEAD_BEEF to addr 5, holds until ack, drops; then lane 3 reads addr 5 → data_mem_write_ack[3] pulses 2 cycles after the write request; ready_ack[3] pulses with mem_read_data[3] = 64'hDEAD_BEEF.
- All 16 lanes read in the same cycle (NUM_CHANNELS=4) → grants go to lanes 0-3, 4-7, 8-11, 12-15 on consecutive cycles; acks arrive in four consecutive cycles; rr returns to 0.
- Lane 7 keeps read_valid high for 5 cycles after its ack → exactly one ready_ack[7] pulse; it is re-served only after valid drops for one cycle.
- Lane 1 writes 1 and lane 9 writes 2 to addr 0x40 on the same edge, with rr=0; lane 2 reads 0x40 on that edge → lane 2 reads 0; a later read of 0x40 returns 2.
- Lane 2 asserts read and write to addr 3 together → write_ack[2] fires first; after valid handling, the read later returns the written value.
- rst asserted one cycle after 4 reads are granted → no acks, mem_busy 0, memory reads back 0 after reset.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - per-lane LSU responder: round-robin grants into a word-addressed data memory
module data_mem_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 7,
  parameter int LANE_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int MEM_LATENCY  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LANE_WIDTH-1:0]                 mem_read_valid,
  input  logic [LANE_WIDTH-1:0]                 mem_write_valid,
  input  logic [LANE_WIDTH-1:0][ADDR_WIDTH-1:0] mem_addr,
  input  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_write_data,
  output logic [LANE_WIDTH-1:0]                 data_mem_ready_ack,
  output logic [LANE_WIDTH-1:0]                 data_mem_write_ack,
  output logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_read_data,
  output logic                                  mem_busy
);

  localparam int RRW   = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lane_state_e;

  lane_state_e                          state_q   [LANE_WIDTH];
  logic [RRW-1:0]                       rr_q, rr_d;
  logic [DATA_WIDTH-1:0]                mem_q     [DEPTH];
  logic [LANE_WIDTH-1:0]                dl_rd_q   [MEM_LATENCY];
  logic [LANE_WIDTH-1:0]                dl_wr_q   [MEM_LATENCY];
  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] dl_data_q [MEM_LATENCY];
  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] rdata_q;

  logic [LANE_WIDTH-1:0] eligible, waiting, grant_d, exit_rd, exit_wr;
  logic [RRW-1:0]        scan_lane [LANE_WIDTH];
  int                    grant_cnt;
  int                    last_lane;

  always_comb begin
    for (int l = 0; l < LANE_WIDTH; l++) begin
      eligible[l] = (state_q[l] == ST_IDLE) && (mem_read_valid[l] || mem_write_valid[l]);
      waiting[l]  = (state_q[l] == ST_WAIT);
    end
  end

  // scan_lane[k] is the k-th lane in priority order starting at rr
  always_comb begin
    grant_d   = '0;
    grant_cnt = 0;
    last_lane = 0;
    for (int k = 0; k < LANE_WIDTH; k++) begin
      scan_lane[k] = RRW'((int'(rr_q) + k) % LANE_WIDTH);
      if (eligible[scan_lane[k]] && grant_cnt < NUM_CHANNELS) begin
        grant_d[scan_lane[k]] = 1'b1;
        grant_cnt             = grant_cnt + 1;
        last_lane             = int'(scan_lane[k]);
      end
    end
    rr_d = rr_q;
    if (grant_cnt > 0) rr_d = RRW'((last_lane + 1) % LANE_WIDTH);
  end

  assign exit_rd            = dl_rd_q[MEM_LATENCY-1];
  assign exit_wr            = dl_wr_q[MEM_LATENCY-1];
  assign data_mem_ready_ack = exit_rd;
  assign data_mem_write_ack = exit_wr;
  assign mem_busy           = |waiting;

  always_comb begin
    for (int l = 0; l < LANE_WIDTH; l++) begin
      mem_read_data[l] = exit_rd[l] ? dl_data_q[MEM_LATENCY-1][l] : rdata_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      rdata_q <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        dl_rd_q[s]   <= '0;
        dl_wr_q[s]   <= '0;
        dl_data_q[s] <= '0;
      end
      for (int l = 0; l < LANE_WIDTH; l++) state_q[l] <= ST_IDLE;
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
    end else begin
      rr_q <= rr_d;
      // a lane holding both valids is granted as a write; its read waits for the next IDLE
      dl_rd_q[0] <= grant_d & ~mem_write_valid;
      dl_wr_q[0] <= grant_d & mem_write_valid;
      for (int l = 0; l < LANE_WIDTH; l++) dl_data_q[0][l] <= mem_q[mem_addr[l]];
      for (int s = 1; s < MEM_LATENCY; s++) begin
        dl_rd_q[s]   <= dl_rd_q[s-1];
        dl_wr_q[s]   <= dl_wr_q[s-1];
        dl_data_q[s] <= dl_data_q[s-1];
      end
      for (int l = 0; l < LANE_WIDTH; l++) begin
        if (exit_rd[l]) rdata_q[l] <= dl_data_q[MEM_LATENCY-1][l];
        case (state_q[l])
          ST_IDLE: if (grant_d[l]) state_q[l] <= ST_WAIT;
          ST_WAIT: if (exit_rd[l] || exit_wr[l]) state_q[l] <= ST_DONE;
          ST_DONE: if (!mem_read_valid[l] && !mem_write_valid[l]) state_q[l] <= ST_IDLE;
          default: state_q[l] <= ST_IDLE;
        endcase
      end
      // later writes in scan order override earlier ones to the same word
      for (int k = 0; k < LANE_WIDTH; k++) begin
        if (grant_d[scan_lane[k]] && mem_write_valid[scan_lane[k]])
          mem_q[mem_addr[scan_lane[k]]] <= mem_write_data[scan_lane[k]];
      end
    end
  end

endmodule
